// File: rtl/long_maze_pkg.sv
// Shared definitions for the long-maze plant.
// Contents: grid dimensions, cell coordinate constants, direction encoding,
// blocked-cell table, wall table, cell-to-zone mapping and the one-hot
// zone encoder used by the plant's registered zone outputs.
// Map (row, col), row 0 at the top:
//   (0,0)=Z6 trap  (0,1) blocked  (0,2) blocked
//   (1,0) corridor (1,1)=Z1       (1,2)=Z2
//   (2,0)=Z5       (2,1)=Z4       (2,2)=Z3
// A wall separates (1,1) and (2,1).
package long_maze_pkg;

    localparam int GRID_ROWS = 3;
    localparam int GRID_COLS = 3;
    localparam logic [1:0] ROW_MAX = 2'(GRID_ROWS - 1);
    localparam logic [1:0] COL_MAX = 2'(GRID_COLS - 1);

    // Direction encoding of the command inputs
    localparam logic DIR_VERT = 1'b1;  // controllable_overt
    localparam logic DIR_POS  = 1'b1;  // controllable_opos: down/right

    typedef enum logic [2:0] {
        ZN_NONE = 3'd0,
        ZN_1    = 3'd1,
        ZN_2    = 3'd2,
        ZN_3    = 3'd3,
        ZN_4    = 3'd4,
        ZN_5    = 3'd5,
        ZN_6    = 3'd6
    } zone_e;

    function automatic logic is_blocked(input logic [1:0] row, input logic [1:0] col);
        return (row == 2'd0) && ((col == 2'd1) || (col == 2'd2));
    endfunction

    // Wall table: the only wall lies between (1,1) and (2,1), crossed in either direction.
    function automatic logic crosses_wall(input logic [1:0] r0, input logic [1:0] c0,
                                          input logic [1:0] r1, input logic [1:0] c1);
        return (c0 == 2'd1) && (c1 == 2'd1) &&
               (((r0 == 2'd1) && (r1 == 2'd2)) || ((r0 == 2'd2) && (r1 == 2'd1)));
    endfunction

    function automatic zone_e cell_zone(input logic [1:0] row, input logic [1:0] col);
        zone_e z;
        z = ZN_NONE;
        case ({row, col})
            {2'd0, 2'd0}: z = ZN_6;
            {2'd1, 2'd1}: z = ZN_1;
            {2'd1, 2'd2}: z = ZN_2;
            {2'd2, 2'd2}: z = ZN_3;
            {2'd2, 2'd1}: z = ZN_4;
            {2'd2, 2'd0}: z = ZN_5;
            default:      z = ZN_NONE;
        endcase
        return z;
    endfunction

    // Bit 0 = zone1 ... bit 5 = zone6; all-zero for corridor/blocked cells.
    function automatic logic [5:0] zone_onehot(input zone_e z);
        logic [5:0] oh;
        oh = 6'b0;
        if (z != ZN_NONE) oh[int'(z) - 1] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/long_maze_plant_if.sv
// Agent/monitor-facing bus of the long-maze plant.
// master modport: the RL agent side (drives step commands and slip, observes state).
// slave modport : the plant (consumes commands, drives zones, position and status).
// Signals: controllable_ostep/overt/opos, islip (commands); controllable_zone1..6,
// pos_row, pos_col, bump, step_cnt[CNT_W], done, trapped (plant outputs).
interface long_maze_plant_if #(
    parameter int CNT_W = 7
);
    logic             controllable_ostep;
    logic             controllable_overt;
    logic             controllable_opos;
    logic             islip;
    logic             controllable_zone1;
    logic             controllable_zone2;
    logic             controllable_zone3;
    logic             controllable_zone4;
    logic             controllable_zone5;
    logic             controllable_zone6;
    logic [1:0]       pos_row;
    logic [1:0]       pos_col;
    logic             bump;
    logic [CNT_W-1:0] step_cnt;
    logic             done;
    logic             trapped;

    modport master (
        output controllable_ostep, controllable_overt, controllable_opos, islip,
        input  controllable_zone1, controllable_zone2, controllable_zone3,
               controllable_zone4, controllable_zone5, controllable_zone6,
               pos_row, pos_col, bump, step_cnt, done, trapped
    );

    modport slave (
        input  controllable_ostep, controllable_overt, controllable_opos, islip,
        output controllable_zone1, controllable_zone2, controllable_zone3,
               controllable_zone4, controllable_zone5, controllable_zone6,
               pos_row, pos_col, bump, step_cnt, done, trapped
    );
endinterface

// File: rtl/long_maze_legal.sv
// Combinational move evaluator for the long-maze plant.
// Ports: pos_row/pos_col (current cell), overt (1 = vertical), opos (1 = +1),
// tgt_row/tgt_col (target cell, equals current cell when off-grid),
// legal (target inside grid, not blocked, no wall crossed).
module long_maze_legal
    import long_maze_pkg::*;
(
    input  logic [1:0] pos_row,
    input  logic [1:0] pos_col,
    input  logic       overt,
    input  logic       opos,
    output logic [1:0] tgt_row,
    output logic [1:0] tgt_col,
    output logic       legal
);
    logic off_grid;

    always_comb begin
        off_grid = 1'b0;
        tgt_row  = pos_row;
        tgt_col  = pos_col;
        if (overt == DIR_VERT) begin
            off_grid = (opos == DIR_POS) ? (pos_row == ROW_MAX) : (pos_row == 2'd0);
            if (!off_grid) tgt_row = (opos == DIR_POS) ? pos_row + 2'd1 : pos_row - 2'd1;
        end else begin
            off_grid = (opos == DIR_POS) ? (pos_col == COL_MAX) : (pos_col == 2'd0);
            if (!off_grid) tgt_col = (opos == DIR_POS) ? pos_col + 2'd1 : pos_col - 2'd1;
        end
        legal = !off_grid && !is_blocked(tgt_row, tgt_col) &&
                !crosses_wall(pos_row, pos_col, tgt_row, tgt_col);
    end
endmodule

// File: rtl/long_maze_plant.sv
// Long-maze environment plant: walks an agent on a fixed 3x3 grid from step
// commands and drives registered one-hot zone outputs for the requirement monitor.
// Ports: clk, rst (synchronous active-high), bus (long_maze_plant_if.slave):
// step commands in, zones/position/bump/step_cnt/done/trapped out.
// Optional feature: define LONG_MAZE_SLIP_EN to make islip suppress the move of an
// accepted step (it still counts, no bump). Without it islip is ignored.
module long_maze_plant
    import long_maze_pkg::*;
#(
    parameter int START_ROW = 1,
    parameter int START_COL = 1,
    parameter int MAX_STEPS = 64,
    parameter int CNT_W     = $clog2(MAX_STEPS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    long_maze_plant_if.slave     bus
);
    localparam logic [1:0]       RST_ROW = 2'(START_ROW);
    localparam logic [1:0]       RST_COL = 2'(START_COL);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STEPS);

    logic [1:0]       row_q, row_d, col_q, col_d;
    logic [5:0]       zone_q, zone_d;
    logic             bump_q, bump_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             trapped_q, trapped_d;

    logic [1:0] tgt_row, tgt_col;
    logic       legal;
    logic       accept, slip, move, enter_z6;

    long_maze_legal u_legal (
        .pos_row (row_q),
        .pos_col (col_q),
        .overt   (bus.controllable_overt),
        .opos    (bus.controllable_opos),
        .tgt_row (tgt_row),
        .tgt_col (tgt_col),
        .legal   (legal)
    );

`ifdef LONG_MAZE_SLIP_EN
    assign slip = bus.islip;
`else
    logic unused_islip;
    assign unused_islip = bus.islip;
    assign slip = 1'b0;
`endif

    always_comb begin
        accept    = bus.controllable_ostep && !done_q;
        move      = accept && !slip && legal;
        enter_z6  = move && (cell_zone(tgt_row, tgt_col) == ZN_6);
        row_d     = move ? tgt_row : row_q;
        col_d     = move ? tgt_col : col_q;
        // A slipped step is not a wall hit, so only unslipped illegal steps bump.
        bump_d    = accept && !slip && !legal;
        cnt_d     = (accept && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
        done_d    = done_q || enter_z6 || (accept && (cnt_d == CNT_MAX));
        trapped_d = trapped_q || enter_z6;
        zone_d    = zone_onehot(cell_zone(row_d, col_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q     <= RST_ROW;
            col_q     <= RST_COL;
            zone_q    <= zone_onehot(cell_zone(RST_ROW, RST_COL));
            bump_q    <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            trapped_q <= 1'b0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            zone_q    <= zone_d;
            bump_q    <= bump_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            trapped_q <= trapped_d;
        end
    end

    assign bus.pos_row            = row_q;
    assign bus.pos_col            = col_q;
    assign bus.controllable_zone1 = zone_q[0];
    assign bus.controllable_zone2 = zone_q[1];
    assign bus.controllable_zone3 = zone_q[2];
    assign bus.controllable_zone4 = zone_q[3];
    assign bus.controllable_zone5 = zone_q[4];
    assign bus.controllable_zone6 = zone_q[5];
    assign bus.bump               = bump_q;
    assign bus.step_cnt           = cnt_q;
    assign bus.done               = done_q;
    assign bus.trapped            = trapped_q;
endmodule

// File: tb/tb_long_maze_plant.sv
// Directed bench for long_maze_plant: a default instance (MAX_STEPS=64) walks the
// legal loop, hits walls/blocks/edges and falls into the trap; a second instance with
// MAX_STEPS=4 exercises the step limit and mid-episode reset.
module tb_long_maze_plant;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    long_maze_plant_if #(.CNT_W(7)) ifa ();
    long_maze_plant_if #(.CNT_W(3)) ifb ();

    long_maze_plant #(.MAX_STEPS(64)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    long_maze_plant #(.MAX_STEPS(4))  dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // zones given as {z6,z5,z4,z3,z2,z1}
    task automatic st_a(input string tag, input int row, input int col, input logic [5:0] zn,
                        input int cnt, input logic bmp, input logic dn, input logic trp);
        chk({tag, ".row"},  32'(ifa.pos_row), 32'(row));
        chk({tag, ".col"},  32'(ifa.pos_col), 32'(col));
        chk({tag, ".zone"}, 32'({ifa.controllable_zone6, ifa.controllable_zone5,
                                 ifa.controllable_zone4, ifa.controllable_zone3,
                                 ifa.controllable_zone2, ifa.controllable_zone1}), 32'(zn));
        chk({tag, ".cnt"},  32'(ifa.step_cnt), 32'(cnt));
        chk({tag, ".bump"}, 32'(ifa.bump), 32'(bmp));
        chk({tag, ".done"}, 32'(ifa.done), 32'(dn));
        chk({tag, ".trap"}, 32'(ifa.trapped), 32'(trp));
    endtask

    task automatic st_b(input string tag, input int row, input int col, input logic [5:0] zn,
                        input int cnt, input logic bmp, input logic dn, input logic trp);
        chk({tag, ".row"},  32'(ifb.pos_row), 32'(row));
        chk({tag, ".col"},  32'(ifb.pos_col), 32'(col));
        chk({tag, ".zone"}, 32'({ifb.controllable_zone6, ifb.controllable_zone5,
                                 ifb.controllable_zone4, ifb.controllable_zone3,
                                 ifb.controllable_zone2, ifb.controllable_zone1}), 32'(zn));
        chk({tag, ".cnt"},  32'(ifb.step_cnt), 32'(cnt));
        chk({tag, ".bump"}, 32'(ifb.bump), 32'(bmp));
        chk({tag, ".done"}, 32'(ifb.done), 32'(dn));
        chk({tag, ".trap"}, 32'(ifb.trapped), 32'(trp));
    endtask

    // Direction letters: U=(vert,-1) D=(vert,+1) L=(horiz,-1) R=(horiz,+1)
    task automatic step_a(input byte d, input logic slip);
        @(negedge clk);
        ifa.controllable_ostep = 1'b1;
        ifa.controllable_overt = (d == "U" || d == "D");
        ifa.controllable_opos  = (d == "D" || d == "R");
        ifa.islip              = slip;
        @(posedge clk);
        #1;
        ifa.controllable_ostep = 1'b0;
        ifa.islip              = 1'b0;
    endtask

    task automatic step_b(input byte d);
        @(negedge clk);
        ifb.controllable_ostep = 1'b1;
        ifb.controllable_overt = (d == "U" || d == "D");
        ifb.controllable_opos  = (d == "D" || d == "R");
        @(posedge clk);
        #1;
        ifb.controllable_ostep = 1'b0;
    endtask

    initial begin
        ifa.controllable_ostep = 1'b0;
        ifa.controllable_overt = 1'b0;
        ifa.controllable_opos  = 1'b0;
        ifa.islip              = 1'b0;
        ifb.controllable_ostep = 1'b0;
        ifb.controllable_overt = 1'b0;
        ifb.controllable_opos  = 1'b0;
        ifb.islip              = 1'b0;

        // 1: reset state, and reset wins over a simultaneous step
        @(negedge clk);
        ifa.controllable_ostep = 1'b1;
        ifa.controllable_opos  = 1'b1;
        @(posedge clk);
        #1;
        st_a("rst_hold", 1, 1, 6'b000001, 0, 0, 0, 0);
        @(negedge clk);
        ifa.controllable_ostep = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        st_a("rst_rel", 1, 1, 6'b000001, 0, 0, 0, 0);

        // 2: legal loop Z1 > Z2 > Z3 > Z4 > Z5 > corridor > Z1
        step_a("R", 0); st_a("loop_R", 1, 2, 6'b000010, 1, 0, 0, 0);
        step_a("D", 0); st_a("loop_D", 2, 2, 6'b000100, 2, 0, 0, 0);
        step_a("L", 0); st_a("loop_L1", 2, 1, 6'b001000, 3, 0, 0, 0);
        step_a("L", 0); st_a("loop_L2", 2, 0, 6'b010000, 4, 0, 0, 0);
        step_a("U", 0); st_a("loop_U", 1, 0, 6'b000000, 5, 0, 0, 0);
        step_a("R", 0); st_a("loop_R2", 1, 1, 6'b000001, 6, 0, 0, 0);

        // 3: wall, blocked cell, grid edge
        step_a("D", 0); st_a("wall", 1, 1, 6'b000001, 7, 1, 0, 0);
        step_a("R", 0); st_a("to_z2", 1, 2, 6'b000010, 8, 0, 0, 0);
        step_a("U", 0); st_a("blocked", 1, 2, 6'b000010, 9, 1, 0, 0);
        step_a("D", 0); st_a("to_z3", 2, 2, 6'b000100, 10, 0, 0, 0);
        step_a("R", 0); st_a("offgrid", 2, 2, 6'b000100, 11, 1, 0, 0);
        @(posedge clk);
        #1;
        st_a("idle", 2, 2, 6'b000100, 11, 0, 0, 0);

        // 4: into the trap from the corridor, then steps are ignored
        step_a("L", 0); st_a("to_z4", 2, 1, 6'b001000, 12, 0, 0, 0);
        step_a("L", 0); st_a("to_z5", 2, 0, 6'b010000, 13, 0, 0, 0);
        step_a("U", 0); st_a("to_corr", 1, 0, 6'b000000, 14, 0, 0, 0);
        step_a("U", 0); st_a("trap", 0, 0, 6'b100000, 15, 0, 1, 1);
        step_a("D", 0); st_a("post_trap1", 0, 0, 6'b100000, 15, 0, 1, 1);
        step_a("R", 0); st_a("post_trap2", 0, 0, 6'b100000, 15, 0, 1, 1);

        // 5: step limit on the MAX_STEPS=4 instance, then mid-episode reset
        step_b("R"); st_b("lim1", 1, 2, 6'b000010, 1, 0, 0, 0);
        step_b("L"); st_b("lim2", 1, 1, 6'b000001, 2, 0, 0, 0);
        step_b("R"); st_b("lim3", 1, 2, 6'b000010, 3, 0, 0, 0);
        step_b("L"); st_b("lim4", 1, 1, 6'b000001, 4, 0, 1, 0);
        step_b("R"); st_b("lim5", 1, 1, 6'b000001, 4, 0, 1, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        st_b("lim_rst", 1, 1, 6'b000001, 0, 0, 0, 0);
        step_b("R"); st_b("lim_after", 1, 2, 6'b000010, 1, 0, 0, 0);

        // 6: slip input after restarting the default instance
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        st_a("rst2", 1, 1, 6'b000001, 0, 0, 0, 0);
        step_a("R", 1);
`ifdef LONG_MAZE_SLIP_EN
        st_a("slip", 1, 1, 6'b000001, 1, 0, 0, 0);
        step_a("D", 1);
        st_a("slip_wall", 1, 1, 6'b000001, 2, 0, 0, 0);
`else
        st_a("slip_ign", 1, 2, 6'b000010, 1, 0, 0, 0);
        step_a("U", 1);
        st_a("slip_ign_blk", 1, 2, 6'b000010, 2, 1, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
